bitonic_serializer: RTL

Downstream stage of the bitonic sorting network. Accepts sorted blocks of 2^P_LOG records on the network's wide output bus and enables it with a one-cycle strobe. Buffers up to 2^FIFO_LOG blocks. Emits them one record per cycle on a narrow valid/ready stream with an end-of-block marker. The network has no backpressure, so this block exposes an early FULL for the upstream feeder and flags any block it has to drop.

---
 rtl/bitonic_serializer.sv | 115 +++++++++++
 1 files changed

// File: rtl/bitonic_serializer.sv
// bitonic_serializer: buffers sorted blocks of 2^P_LOG records coming off the
// bitonic network's wide bus and streams them out one record per cycle on a
// valid/ready interface with an end-of-block marker.
// Optional build macro: BITONIC_SER_DESCEND_EN -- when defined, lanes are
// emitted highest-first (descending keys) instead of lane 0 first.
module bitonic_serializer #(
    parameter int P_LOG    = 4,
    parameter int DATW     = 64,
    parameter int FIFO_LOG = 2,
    parameter int HEADROOM = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [(DATW<<P_LOG)-1:0] DIN,
    input  logic                     DINEN,
    output logic                     FULL,
    output logic                     OVF,
    output logic [DATW-1:0]          DOT,
    output logic                     DOTEN,
    output logic                     DOTLAST,
    input  logic                     DOTRDY
);

    localparam int DEPTH = 1 << FIFO_LOG;
    localparam int OCCW  = FIFO_LOG + 1;

    typedef logic [OCCW-1:0]          occ_t;
    typedef logic [(DATW<<P_LOG)-1:0] blk_t;
    typedef enum logic {IDLE, EMIT}   state_t;

    localparam occ_t DEPTH_O = occ_t'(DEPTH);
    localparam occ_t FULL_AT = occ_t'(DEPTH - HEADROOM);

    blk_t                mem [DEPTH];
    logic [FIFO_LOG-1:0] wr_ptr, rd_ptr;
    occ_t                occ, occ_next;
    logic [P_LOG-1:0]    lane, sel;
    state_t              state, state_next;

    logic                wr_en, drop, load, lane_last, pop;
    blk_t                head_blk;
    logic [DATW-1:0]     head_rec;

`ifdef BITONIC_SER_DESCEND_EN
    assign sel = ~lane;
`else
    assign sel = lane;
`endif

    assign head_blk = mem[rd_ptr];
    assign head_rec = head_blk[DATW*int'(sel) +: DATW];

    // Handshake decode: occupancy is judged before the same-cycle pop, so a
    // write into a full FIFO is dropped even when the head is leaving.
    always_comb begin
        wr_en     = DINEN && (occ != DEPTH_O);
        drop      = DINEN && (occ == DEPTH_O);
        load      = (!DOTEN || DOTRDY) && (occ != '0);
        lane_last = (lane == {P_LOG{1'b1}});
        pop       = load && lane_last;
        occ_next  = occ + occ_t'(wr_en) - occ_t'(pop);
    end

    // Read-side FSM next state: EMIT while records flow, back to IDLE once the
    // final record is taken and nothing else is buffered.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and no latch is inferred.
        state_next = state;
        case (state)
            IDLE: if (load) state_next = EMIT;
            EMIT: if (DOTEN && DOTRDY && DOTLAST && (occ_next == '0)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Block storage write port.
    always_ff @(posedge CLK) begin
        // NOTE: the block memory is deliberately not reset; pointers and occupancy define which entries are valid.
        if (wr_en) mem[wr_ptr] <= DIN;
    end

    // Pointers, occupancy, flags, lane counter and the registered output stage.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            lane    <= '0;
            state   <= IDLE;
            FULL    <= 1'b0;
            OVF     <= 1'b0;
            DOT     <= '0;
            DOTEN   <= 1'b0;
            DOTLAST <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
            occ   <= occ_next;
            FULL  <= (occ_next >= FULL_AT);
            if (drop)  OVF    <= 1'b1;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (load) begin
                DOT     <= head_rec;
                DOTEN   <= 1'b1;
                DOTLAST <= lane_last;
                lane    <= lane + 1'b1;
            end else if (DOTEN && DOTRDY) begin
                DOTEN   <= 1'b0;
                DOTLAST <= 1'b0;
            end
        end
    end

endmodule
